// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, PID class helpers and the packet builder FSM states.
package usb_pkg;

   // PRE and ERR share one code; the meaning depends on context, so one name covers both.
   typedef enum logic [3:0] {
      PID_OUT   = 4'b0001,
      PID_IN    = 4'b1001,
      PID_SOF   = 4'b0101,
      PID_SETUP = 4'b1101,
      PID_DATA0 = 4'b0011,
      PID_DATA1 = 4'b1011,
      PID_DATA2 = 4'b0111,
      PID_MDATA = 4'b1111,
      PID_ACK   = 4'b0010,
      PID_NAK   = 4'b1010,
      PID_STALL = 4'b1110,
      PID_NYET  = 4'b0110,
      PID_PRE   = 4'b1100,
      PID_SPLIT = 4'b1000,
      PID_PING  = 4'b0100
   } pid_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SOP,
      ST_BODY,
      ST_DONE
   } state_t;

   function automatic logic is_token(input logic [3:0] pid);
      case (pid)
         PID_OUT, PID_IN, PID_SETUP, PID_PING, PID_SOF: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   function automatic logic is_data(input logic [3:0] pid);
      case (pid)
         PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/usb_tx_packet_builder_if.sv
// Command, payload-write and transmit-stream signals of the USB TX packet builder.
interface usb_tx_packet_builder_if #(
   parameter int unsigned CNT_W = 7
);
   logic [7:0]       wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic [CNT_W-1:0] buf_count;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_pid;
   logic [10:0]      cmd_token;
   logic [CNT_W-1:0] cmd_len;
   logic             cmd_keep;

   logic             busy;
   logic             done;
   logic             cmd_err;

   logic [7:0]       tx_packet_data;
   logic             tx_packet_valid;
   logic             tx_packet_sop;
   logic             tx_packet_eop;
   logic             tx_packet_ready;
   logic [3:0]       tx_pid;

   // Protocol-engine / TX-FSM side.
   modport master (
      output wr_data, wr_valid, cmd_valid, cmd_pid, cmd_token, cmd_len, cmd_keep,
             tx_packet_ready,
      input  wr_ready, buf_count, cmd_ready, busy, done, cmd_err, tx_packet_data,
             tx_packet_valid, tx_packet_sop, tx_packet_eop, tx_pid
   );

   // Packet builder side.
   modport slave (
      input  wr_data, wr_valid, cmd_valid, cmd_pid, cmd_token, cmd_len, cmd_keep,
             tx_packet_ready,
      output wr_ready, buf_count, cmd_ready, busy, done, cmd_err, tx_packet_data,
             tx_packet_valid, tx_packet_sop, tx_packet_eop, tx_pid
   );

endinterface

// File: rtl/usb_tx_payload_ram.sv
// Payload byte store: one write port, one synchronous read port (data valid the cycle after
// the address is presented).
module usb_tx_payload_ram #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/usb_tx_packet_builder.sv
// Turns packet commands into the TX FSM's sop/valid/eop byte stream; DATAx payload comes from
// a local buffer that can be kept for retries.
module usb_tx_packet_builder
   import usb_pkg::*;
#(
   parameter int unsigned MAX_PKT = 64,
   parameter int unsigned CNT_W   = $clog2(MAX_PKT) + 1
) (
   input logic                   clk,
   input logic                   rst_n,
   usb_tx_packet_builder_if.slave bus
);

   localparam int unsigned ADDR_W = $clog2(MAX_PKT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] buf_count_q, buf_count_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [3:0]       pid_q, pid_d;
   logic [10:0]      token_q, token_d;
   logic             keep_q, keep_d;
   logic             beat_q, beat_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             sop_q, sop_d;
   logic             eop_q, eop_d;
   logic             err_q, err_d;

   logic             idle;
   logic             wr_fire;
   logic             cmd_fire;
   logic             cmd_bad;
   logic             tx_fire;
   logic             load_next;
   logic [7:0]       ram_rd_data;

   assign idle     = (state_q == ST_IDLE);
   assign wr_fire  = bus.wr_valid && bus.wr_ready;
   assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
   assign tx_fire  = valid_q && bus.tx_packet_ready;
   // Checked against the pre-write count, so a same-cycle write never counts toward cmd_len.
   assign cmd_bad  = is_data(bus.cmd_pid) &&
                     ((bus.cmd_len == '0) || (bus.cmd_len > buf_count_q));

   // Read address is the next-state pointer, so ram_rd_data always holds buf[rd_ptr_q].
   usb_tx_payload_ram #(
      .DEPTH  (MAX_PKT),
      .ADDR_W (ADDR_W)
   ) u_payload_ram (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (bus.wr_data),
      .rd_addr (rd_ptr_d[ADDR_W-1:0]),
      .rd_data (ram_rd_data)
   );

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      buf_count_d = buf_count_q;
      rd_ptr_d    = rd_ptr_q;
      len_d       = len_q;
      pid_d       = pid_q;
      token_d     = token_q;
      keep_d      = keep_q;
      beat_d      = beat_q;
      data_d      = data_q;
      valid_d     = valid_q;
      sop_d       = sop_q;
      eop_d       = eop_q;
      err_d       = 1'b0;
      load_next   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (wr_fire) begin
               wr_ptr_d    = wr_ptr_q + CNT_W'(1);
               buf_count_d = buf_count_q + CNT_W'(1);
            end
            if (cmd_fire) begin
               if (cmd_bad) begin
                  err_d = 1'b1;
               end else begin
                  pid_d   = bus.cmd_pid;
                  token_d = bus.cmd_token;
                  len_d   = bus.cmd_len;
                  keep_d  = bus.cmd_keep;
                  data_d  = {~bus.cmd_pid, bus.cmd_pid};
                  valid_d = 1'b1;
                  sop_d   = 1'b1;
                  eop_d   = !is_token(bus.cmd_pid) && !is_data(bus.cmd_pid);
                  state_d = ST_SOP;
               end
            end
         end
         ST_SOP: begin
            if (tx_fire) begin
               sop_d = 1'b0;
               if (eop_q) begin
                  valid_d = 1'b0;
                  eop_d   = 1'b0;
                  data_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  beat_d    = 1'b0;
                  load_next = 1'b1;
                  state_d   = ST_BODY;
               end
            end
         end
         ST_BODY: begin
            if (tx_fire) begin
               if (eop_q) begin
                  valid_d = 1'b0;
                  eop_d   = 1'b0;
                  data_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  beat_d    = 1'b1;
                  load_next = 1'b1;
               end
            end
         end
         ST_DONE: begin
            rd_ptr_d = '0;
            beat_d   = 1'b0;
            if (!keep_q) begin
               wr_ptr_d    = '0;
               buf_count_d = '0;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Body beat loader: payload byte for DATAx, otherwise the two token bytes.
      if (load_next) begin
         if (is_data(pid_q)) begin
            data_d   = ram_rd_data;
            eop_d    = (rd_ptr_q == len_q - CNT_W'(1));
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
         end else begin
            data_d = beat_d ? {5'b0, token_q[10:8]} : token_q[7:0];
            eop_d  = beat_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         buf_count_q <= '0;
         rd_ptr_q    <= '0;
         len_q       <= '0;
         pid_q       <= '0;
         token_q     <= '0;
         keep_q      <= 1'b0;
         beat_q      <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         buf_count_q <= buf_count_d;
         rd_ptr_q    <= rd_ptr_d;
         len_q       <= len_d;
         pid_q       <= pid_d;
         token_q     <= token_d;
         keep_q      <= keep_d;
         beat_q      <= beat_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         err_q       <= err_d;
      end
   end

   // Handshake readies are gated by rst_n so nothing is accepted while held in reset.
   assign bus.wr_ready        = rst_n && idle && (buf_count_q < CNT_W'(MAX_PKT));
   assign bus.cmd_ready       = rst_n && idle;
   assign bus.buf_count       = buf_count_q;
   assign bus.busy            = !idle;
   assign bus.done            = (state_q == ST_DONE);
   assign bus.cmd_err         = err_q;
   assign bus.tx_packet_data  = data_q;
   assign bus.tx_packet_valid = valid_q;
   assign bus.tx_packet_sop   = sop_q;
   assign bus.tx_packet_eop   = eop_q;
   assign bus.tx_pid          = pid_q;

endmodule

// File: tb/tb_usb_tx_packet_builder.sv
// Scoreboard bench for usb_tx_packet_builder: a queue-based packet model feeds expected beats
// to a monitor that checks every accepted beat, stall stability, done and cmd_err.
module tb_usb_tx_packet_builder;

   localparam int unsigned MAX_PKT = 64;
   localparam int unsigned CNT_W   = $clog2(MAX_PKT) + 1;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic [3:0] pid;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   usb_tx_packet_builder_if #(.CNT_W(CNT_W)) bus ();

   usb_tx_packet_builder #(
      .MAX_PKT (MAX_PKT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   beat_t        exp_q[$];
   logic         err_q[$];
   logic [7:0]   model_buf[$];
   logic [3:0]   model_pid = 4'h0;
   int           ready_mode = 0;
   int unsigned  cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic beat_t mk(input logic [7:0] d, input logic s, input logic e,
                                input logic [3:0] p);
      beat_t b;
      b.data = d;
      b.sop  = s;
      b.eop  = e;
      b.pid  = p;
      return b;
   endfunction

   // 0 = handshake, 1 = token (OUT/IN/SETUP/PING/SOF), 2 = data (DATA0/1/2, MDATA)
   function automatic int pid_class(input logic [3:0] pid);
      case (pid)
         4'h1, 4'h9, 4'hD, 4'h4, 4'h5: return 1;
         4'h3, 4'hB, 4'h7, 4'hF:       return 2;
         default:                      return 0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Downstream ready patterns: always, toggling, three-cycle stalls, random.
   initial begin
      bus.tx_packet_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (ready_mode)
            0:       bus.tx_packet_ready = 1'b1;
            1:       bus.tx_packet_ready = cyc[0];
            2:       bus.tx_packet_ready = ((cyc % 4) == 0);
            default: bus.tx_packet_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: samples on the falling edge, pops expectations on each accepted beat/command.
   beat_t got, held, want;
   logic  held_v    = 1'b0;
   logic  done_want = 1'b0;
   logic  err_pend  = 1'b0;
   logic  err_want  = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_v    = 1'b0;
            done_want = 1'b0;
            err_pend  = 1'b0;
         end else begin
            chk("done", 32'(bus.done), 32'(done_want));
            chk("cmd_err", 32'(bus.cmd_err), 32'(err_pend ? err_want : 1'b0));
            err_pend = 1'b0;
            if (bus.cmd_valid && bus.cmd_ready) begin
               chk("cmd_expected", 32'(err_q.size() != 0), 32'd1);
               if (err_q.size() != 0) begin
                  err_want = err_q.pop_front();
                  err_pend = 1'b1;
               end
            end
            got = mk(bus.tx_packet_data, bus.tx_packet_sop, bus.tx_packet_eop, bus.tx_pid);
            done_want = 1'b0;
            if (bus.tx_packet_valid) begin
               if (held_v) chk("stall_stable", 32'(got), 32'(held));
               if (bus.tx_packet_ready) begin
                  held_v = 1'b0;
                  if (exp_q.size() == 0) begin
                     chk("beat_unexpected", 32'(got), 32'hffff_ffff);
                  end else begin
                     want = exp_q.pop_front();
                     chk("beat", 32'(got), 32'(want));
                  end
                  done_want = bus.tx_packet_eop;
               end else begin
                  held   = got;
                  held_v = 1'b1;
               end
            end else begin
               if (held_v) chk("valid_hold", 32'(bus.tx_packet_valid), 32'd1);
               held_v = 1'b0;
            end
         end
      end
   end

   task automatic write_byte(input logic [7:0] b);
      int n = 0;
      bus.wr_data  = b;
      bus.wr_valid = 1'b1;
      while (!bus.wr_ready && n < 50) begin
         step();
         n++;
      end
      if (!bus.wr_ready) begin
         chk("wr_ready_timeout", 32'(bus.wr_ready), 32'd1);
         bus.wr_valid = 1'b0;
         return;
      end
      model_buf.push_back(b);
      step();
      bus.wr_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [3:0] pid, input logic [10:0] tok, input int len,
                           input logic keep, input bit wait_done);
      int cls = pid_class(pid);
      int n   = 0;
      bit bad;
      bus.cmd_pid   = pid;
      bus.cmd_token = tok;
      bus.cmd_len   = CNT_W'(len);
      bus.cmd_keep  = keep;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 50) begin
         step();
         n++;
      end
      if (!bus.cmd_ready) begin
         chk("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
         bus.cmd_valid = 1'b0;
         return;
      end
      bad = (cls == 2) && (len == 0 || len > model_buf.size());
      err_q.push_back(bad);
      if (!bad) begin
         exp_q.push_back(mk({~pid, pid}, 1'b1, cls == 0, pid));
         if (cls == 1) begin
            exp_q.push_back(mk(tok[7:0], 1'b0, 1'b0, pid));
            exp_q.push_back(mk({5'b0, tok[10:8]}, 1'b0, 1'b1, pid));
         end else if (cls == 2) begin
            for (int i = 0; i < len; i++) exp_q.push_back(mk(model_buf[i], 1'b0, i == len - 1, pid));
         end
         if (!keep) model_buf.delete();
         model_pid = pid;
      end
      step();
      bus.cmd_valid = 1'b0;
      if (bad) begin
         step();
         chk("reject_tx_pid", 32'(bus.tx_pid), 32'(model_pid));
         chk("reject_busy", 32'(bus.busy), 32'd0);
         chk("reject_buf_count", 32'(bus.buf_count), 32'(model_buf.size()));
      end else if (wait_done) begin
         n = 0;
         while (bus.busy && n < 400) begin
            step();
            n++;
         end
         chk("pkt_complete", 32'(bus.busy), 32'd0);
         step();
         chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
         chk("buf_count", 32'(bus.buf_count), 32'(model_buf.size()));
      end
   endtask

   task automatic check_reset_outputs(input string name);
      chk(name, 32'({bus.tx_packet_valid, bus.tx_packet_sop, bus.tx_packet_eop,
                     bus.tx_packet_data, bus.tx_pid, bus.busy, bus.done, bus.cmd_err,
                     bus.wr_ready, bus.cmd_ready, bus.buf_count}), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      bus.wr_data   = '0;
      bus.wr_valid  = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_pid   = '0;
      bus.cmd_token = '0;
      bus.cmd_len   = '0;
      bus.cmd_keep  = 1'b0;
      rst_n         = 1'b0;
      repeat (3) step();
      check_reset_outputs("reset_outputs");
      rst_n = 1'b1;
      step();

      // ACK handshake
      ready_mode = 0;
      send_cmd(4'h2, 11'h0, 0, 1'b0, 1'b1);
      // IN token addr 5 endp 1 with three-cycle stalls
      ready_mode = 2;
      send_cmd(4'h9, 11'h085, 0, 1'b0, 1'b1);
      // DATA1 of three bytes with toggling ready
      ready_mode = 1;
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      send_cmd(4'hB, 11'h0, 3, 1'b0, 1'b1);
      // Rejected DATA0 commands: too long, then zero length
      ready_mode = 0;
      write_byte(8'hA1);
      write_byte(8'hA2);
      write_byte(8'hA3);
      send_cmd(4'h3, 11'h0, 4, 1'b0, 1'b1);
      send_cmd(4'h3, 11'h0, 0, 1'b0, 1'b1);
      send_cmd(4'h2, 11'h0, 0, 1'b0, 1'b1);
      // Retry: keep the payload, resend, then release it
      write_byte(8'h5C);
      write_byte(8'hE7);
      send_cmd(4'h3, 11'h0, 2, 1'b1, 1'b1);
      send_cmd(4'h3, 11'h0, 2, 1'b0, 1'b1);

      for (int it = 0; it < 40; it++) begin
         int nw = $urandom_range(0, 6);
         ready_mode = $urandom_range(0, 3);
         for (int k = 0; k < nw && model_buf.size() < MAX_PKT; k++) write_byte(8'($urandom));
         send_cmd(4'($urandom_range(1, 15)), 11'($urandom),
                  $urandom_range(0, model_buf.size() + 1), 1'($urandom_range(0, 1)), 1'b1);
      end

      // Fill to capacity, start a full DATA0, then reset in the middle of the body
      ready_mode = 0;
      send_cmd(4'hA, 11'h0, 0, 1'b0, 1'b1);
      for (int i = 0; i < MAX_PKT; i++) begin
         if (i == MAX_PKT - 1) chk("wr_ready_last_slot", 32'(bus.wr_ready), 32'd1);
         write_byte(8'(i * 7 + 3));
      end
      chk("buf_full_count", 32'(bus.buf_count), 32'(MAX_PKT));
      chk("wr_ready_full", 32'(bus.wr_ready), 32'd0);
      send_cmd(4'h3, 11'h0, MAX_PKT, 1'b0, 1'b0);
      repeat (6) step();
      chk("mid_body_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      step();
      check_reset_outputs("mid_packet_reset");
      exp_q.delete();
      err_q.delete();
      model_buf.delete();
      model_pid = 4'h0;
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("post_reset_buf_count", 32'(bus.buf_count), 32'd0);
      send_cmd(4'h2, 11'h0, 0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
